// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op codes and FSM states for the multiply/divide unit
package muldiv_pkg;

  // Operation codes presented on op
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one combinational step of shift-add multiply or restoring divide
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] mq_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] mq_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] shifted;

  // Multiply: add multiplicand when the low multiplier bit is set, then shift {acc,mq} right.
  // Divide: shift {acc,mq} left, subtract divisor if it fits, shift quotient bit into mq.
  always_comb begin
    sum     = acc_i + (mq_i[0] ? m_i : '0);
    shifted = {acc_i, mq_i[WIDTH-1]};
    acc_o   = '0;
    mq_o    = '0;
    if (is_div_i) begin
      if (shifted >= {1'b0, m_i}) begin
        acc_o = (WIDTH+1)'(shifted - {1'b0, m_i});
        mq_o  = {mq_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = (WIDTH+1)'(shifted);
        mq_o  = {mq_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {1'b0, sum[WIDTH:1]};
      mq_o  = {sum[0], mq_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MIPS-style multiply/divide unit with HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit SIGN_FIX = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               is_div_q, neg_q, rem_neg_q, dbz_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH:0]     acc_q, m_q;
  logic [WIDTH-1:0]   mq_q;
  logic               busy_q, done_q, dbz_out_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               is_div_d, signed_op_d, a_neg_d, b_neg_d;
  logic [WIDTH-1:0]   mag_a_d;
  logic [WIDTH:0]     mag_b_d;
  logic [WIDTH:0]     acc_d;
  logic [WIDTH-1:0]   mq_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   hi_fix_d, lo_fix_d;

  // Decode the incoming request into unsigned magnitudes plus sign bookkeeping
  always_comb begin
    is_div_d    = !((op == OP_MULT) || (op == OP_MULTU));
    signed_op_d = SIGN_FIX && ((op == OP_MULT) || (op == OP_DIV));
    a_neg_d     = signed_op_d && a[WIDTH-1];
    b_neg_d     = signed_op_d && b[WIDTH-1];
    mag_a_d     = a_neg_d ? (~a + WIDTH'(1)) : a;
    mag_b_d     = b_neg_d ? (~{b[WIDTH-1], b} + (WIDTH+1)'(1)) : {1'b0, b};
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .mq_i     (mq_q),
    .m_i      (m_q),
    .acc_o    (acc_d),
    .mq_o     (mq_d)
  );

  // Sign correction and divide-by-zero override applied in the FIX cycle
  always_comb begin
    prod_d   = {acc_q[WIDTH-1:0], mq_q};
    hi_fix_d = '0;
    lo_fix_d = '0;
    if (!is_div_q) begin
      if (neg_q) prod_d = -prod_d;
      hi_fix_d = prod_d[2*WIDTH-1:WIDTH];
      lo_fix_d = prod_d[WIDTH-1:0];
    end else if (dbz_q) begin
      hi_fix_d = a_q;
      lo_fix_d = '1;
    end else begin
      lo_fix_d = neg_q ? -mq_q : mq_q;
      hi_fix_d = rem_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end
  end

  // Sequencer, iteration counter, operand latches and HI/LO registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
      a_q       <= '0;
      acc_q     <= '0;
      m_q       <= '0;
      mq_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            is_div_q  <= is_div_d;
            neg_q     <= a_neg_d ^ b_neg_d;
            rem_neg_q <= a_neg_d;
            dbz_q     <= is_div_d && (b == '0);
            a_q       <= a;
            acc_q     <= '0;
            mq_q      <= mag_a_d;
            m_q       <= mag_b_d;
            cnt_q     <= CW'(WIDTH);
            busy_q    <= 1'b1;
            state_q   <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          mq_q  <= mq_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          hi_q      <= hi_fix_d;
          lo_q      <= lo_fix_d;
          done_q    <= 1'b1;
          dbz_out_q <= dbz_q;
          busy_q    <= 1'b0;
          state_q   <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
      if (!busy_q) begin
        if (hi_wr) hi_q <= wr_data;
        if (lo_wr) lo_q <= wr_data;
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_out_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
